// File: rtl/flag_branch_unit_if.sv
// Bundles the ALU-completion, branch-request and flag/resolve signals of flag_branch_unit.
// The master side drives the ALU and branch inputs; the slave side returns flags and the resolve result.
interface flag_branch_unit_if #(
  parameter int W = 16
);
  logic         ex_valid;
  logic [3:0]   ex_opcode;
  logic [W-1:0] alu_result;
  logic         alu_ovfl;
  logic         stall;
  logic         flush;
  logic         br_valid;
  logic [2:0]   br_ccc;
  logic         br_taken;
  logic         br_done;
  logic         flag_z;
  logic         flag_v;
  logic         flag_n;

  modport master (
    output ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, br_valid, br_ccc,
    input  br_taken, br_done, flag_z, flag_v, flag_n
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, br_valid, br_ccc,
    output br_taken, br_done, flag_z, flag_v, flag_n
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register fed by completing ALU ops, plus a 1-cycle branch-condition resolver.
// Stall holds flags and br_taken (br_done low); flush only cancels the flag write.
module flag_branch_unit #(
  parameter bit BYPASS = 1'b1,
  parameter int W      = 16
) (
  input logic             clk,
  input logic             rst,
  flag_branch_unit_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  logic flag_z, flag_v, flag_n;
  logic br_taken, br_done;
  logic we, wr_all, wr_z;
  logic nz, nv, nn;
  logic ez, ev, en;
  logic cond;

  assign we     = bus.ex_valid & ~bus.stall & ~bus.flush;
  assign wr_all = (bus.ex_opcode == OP_ADD) || (bus.ex_opcode == OP_SUB);
  assign wr_z   = wr_all || (bus.ex_opcode == OP_XOR) || (bus.ex_opcode == OP_SLL) ||
                  (bus.ex_opcode == OP_SRA) || (bus.ex_opcode == OP_ROR);

  // A saturated ADD/SUB result is taken as-is for Z and N.
  assign nz = (we && wr_z)   ? (bus.alu_result == '0)  : flag_z;
  assign nv = (we && wr_all) ? bus.alu_ovfl            : flag_v;
  assign nn = (we && wr_all) ? bus.alu_result[W-1]     : flag_n;

  assign ez = BYPASS ? nz : flag_z;
  assign ev = BYPASS ? nv : flag_v;
  assign en = BYPASS ? nn : flag_n;

  always_comb begin
    cond = 1'b0;
    unique case (bus.br_ccc)
      3'b000:  cond = ~ez;
      3'b001:  cond = ez;
      3'b010:  cond = ~ez & ~en;
      3'b011:  cond = en;
      3'b100:  cond = ez | ~en;
      3'b101:  cond = en | ez;
      3'b110:  cond = ev;
      default: cond = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      flag_z <= nz;
      flag_v <= nv;
      flag_n <= nn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_taken <= 1'b0;
      br_done  <= 1'b0;
    end else if (bus.br_valid && !bus.stall) begin
      br_taken <= cond;
      br_done  <= 1'b1;
    end else begin
      br_done  <= 1'b0;
    end
  end

  assign bus.flag_z   = flag_z;
  assign bus.flag_v   = flag_v;
  assign bus.flag_n   = flag_n;
  assign bus.br_taken = br_taken;
  assign bus.br_done  = br_done;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench: identical stimulus drives a BYPASS=1 and a BYPASS=0 instance side by side.
module tb_flag_branch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = 4'h0;
  logic [15:0] alu_result = 16'h0;
  logic        alu_ovfl = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_ccc = 3'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flag_branch_unit_if #(.W(16)) if1 ();
  flag_branch_unit_if #(.W(16)) if0 ();

  assign if1.ex_valid = ex_valid;    assign if0.ex_valid = ex_valid;
  assign if1.ex_opcode = ex_opcode;  assign if0.ex_opcode = ex_opcode;
  assign if1.alu_result = alu_result; assign if0.alu_result = alu_result;
  assign if1.alu_ovfl = alu_ovfl;    assign if0.alu_ovfl = alu_ovfl;
  assign if1.stall = stall;          assign if0.stall = stall;
  assign if1.flush = flush;          assign if0.flush = flush;
  assign if1.br_valid = br_valid;    assign if0.br_valid = br_valid;
  assign if1.br_ccc = br_ccc;        assign if0.br_ccc = br_ccc;

  flag_branch_unit #(.BYPASS(1'b1), .W(16)) dut_byp (.clk(clk), .rst(rst), .bus(if1.slave));
  flag_branch_unit #(.BYPASS(1'b0), .W(16)) dut_reg (.clk(clk), .rst(rst), .bus(if0.slave));

  typedef struct {
    logic       z, v, n;
    logic [7:0] exp_taken;   // bit c = expected br_taken for ccc c
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] opc, input logic [15:0] res, input logic ovf);
    ex_valid   = 1'b1;
    ex_opcode  = opc;
    alu_result = res;
    alu_ovfl   = ovf;
  endtask

  function automatic logic [2:0] zvn1();
    return {if1.flag_z, if1.flag_v, if1.flag_n};
  endfunction

  function automatic logic [2:0] zvn0();
    return {if0.flag_z, if0.flag_v, if0.flag_n};
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'b1001_0101};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'b1010_1001};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'b1101_0101};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'b1110_1001};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'b1011_0010};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'b1011_1010};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'b1111_0010};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'b1111_1010};

    // Reset held while an ADD of 0 and a branch are presented
    op(4'b0000, 16'h0000, 1'b0);
    br_valid = 1'b1; br_ccc = 3'b111;
    tick();
    chk("rst_flags_byp", 8'(zvn1()), 8'h0);
    chk("rst_flags_reg", 8'(zvn0()), 8'h0);
    chk("rst_done", 8'(if1.br_done), 8'h0);
    chk("rst_taken", 8'(if1.br_taken), 8'h0);
    rst = 1'b0; br_valid = 1'b0;
    tick();
    chk("post_rst_z", 8'(zvn1()), 8'b100);
    chk("post_rst_done", 8'(if1.br_done), 8'h0);

    // Opcode class masking
    op(4'b0001, 16'h8000, 1'b1); tick();
    chk("sub_sat", 8'(zvn1()), 8'b011);
    op(4'b0010, 16'h0000, 1'b0); tick();
    chk("xor_z", 8'(zvn1()), 8'b111);
    op(4'b0011, 16'h0000, 1'b0); tick();
    chk("red_none", 8'(zvn1()), 8'b111);
    op(4'b1000, 16'h0001, 1'b0); tick();
    chk("op8_none", 8'(zvn1()), 8'b111);
    op(4'b0100, 16'h8000, 1'b0); tick();
    chk("sll_z_only", 8'(zvn0()), 8'b011);
    op(4'b0111, 16'h0000, 1'b1); tick();
    chk("paddsb_none", 8'(zvn0()), 8'b011);

    // Condition-code sweep over all flag combinations
    for (int r = 0; r < 8; r++) begin
      op(4'b0000, {vecs[r].n, 15'h0001}, vecs[r].v); tick();
      op(4'b0010, vecs[r].z ? 16'h0000 : 16'h0001, 1'b0); tick();
      ex_valid = 1'b0;
      chk($sformatf("sweep_flags_%0d", r), 8'(zvn1()), 8'({vecs[r].z, vecs[r].v, vecs[r].n}));
      for (int c = 0; c < 8; c++) begin
        br_valid = 1'b1; br_ccc = 3'(c);
        tick();
        chk($sformatf("taken_byp_%0d_%0d", r, c), 8'(if1.br_taken), 8'(vecs[r].exp_taken[c]));
        chk($sformatf("taken_reg_%0d_%0d", r, c), 8'(if0.br_taken), 8'(vecs[r].exp_taken[c]));
        chk($sformatf("done_%0d_%0d", r, c), 8'(if1.br_done), 8'h1);
      end
      br_valid = 1'b0;
      tick();
      chk($sformatf("done_drop_%0d", r), 8'(if0.br_done), 8'h0);
    end

    // Bypass: flag write and EQ branch in the same cycle
    op(4'b0000, 16'h0001, 1'b0); tick();
    op(4'b0000, 16'h0000, 1'b0); br_valid = 1'b1; br_ccc = 3'b001;
    tick();
    chk("byp_taken", 8'(if1.br_taken), 8'h1);
    chk("nobyp_taken", 8'(if0.br_taken), 8'h0);
    chk("byp_z", 8'(zvn1()), 8'b100);

    // Stall: flags and br_taken hold, br_done low, then resolve on release
    op(4'b0000, 16'h0001, 1'b0); br_valid = 1'b1; br_ccc = 3'b000;
    tick();
    chk("pre_stall_taken", 8'(if1.br_taken), 8'h1);
    op(4'b0000, 16'h0000, 1'b0); br_ccc = 3'b001; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_flags", 8'(zvn1()), 8'b000);
      chk("stall_done", 8'(if1.br_done), 8'h0);
      chk("stall_taken", 8'(if1.br_taken), 8'h1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_done", 8'(if1.br_done), 8'h1);
    chk("unstall_byp", 8'(if1.br_taken), 8'h1);
    chk("unstall_reg", 8'(if0.br_taken), 8'h0);
    chk("unstall_z", 8'(zvn0()), 8'b100);

    // Flush: flag write cancelled, branch still resolves against held flags
    op(4'b0000, 16'h0001, 1'b0); br_valid = 1'b0; tick();
    op(4'b0000, 16'h0000, 1'b0); flush = 1'b1; br_valid = 1'b1; br_ccc = 3'b001;
    tick();
    chk("flush_flags", 8'(zvn1()), 8'b000);
    chk("flush_done", 8'(if1.br_done), 8'h1);
    chk("flush_byp", 8'(if1.br_taken), 8'h0);
    chk("flush_reg", 8'(if0.br_taken), 8'h0);
    flush = 1'b0;

    // Async reset between edges after Z=1 and a resolved branch
    op(4'b0000, 16'h0000, 1'b0); br_valid = 1'b1; br_ccc = 3'b111;
    tick();
    chk("pre_arst_z", 8'(zvn1()), 8'b100);
    chk("pre_arst_done", 8'(if1.br_done), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_z", 8'(if1.flag_z), 8'h0);
    chk("arst_done", 8'(if1.br_done), 8'h0);
    chk("arst_taken", 8'(if0.br_taken), 8'h0);
    tick();
    ex_valid = 1'b0; br_valid = 1'b0; rst = 1'b0;
    tick();
    chk("arst_no_pulse", 8'(if1.br_done), 8'h0);
    chk("arst_flags", 8'(zvn0()), 8'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
